riscv_lsu: RTL and testbench

Load/store unit on the data-memory side of the control-unit decode outputs. It consumes load, store, fun3, the unshifted mem_mask and the effective address. It drives a valid/ready request bus to data memory with byte-lane-aligned write data and strobes, and returns sign- or zero-extended load data to writeback. While a memory op is outstanding it stalls the pipeline.

---
 rtl/riscv_lsu.sv | 230 +++++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between execute-stage decode outputs and a
// valid/ready data-memory bus. Aligns store data and byte strobes to the
// word lane, issues one request per memory op, and returns sign- or
// zero-extended load data. Stalls the pipeline while an op is in flight.
//
// Optional feature (compile-time macro LSU_TIMEOUT_EN): when defined, a
// 16-bit watchdog aborts a REQ/WAIT that lasts TIMEOUT_CYCLES cycles and
// pulses bus_error; when undefined, bus_error is tied low and waits are
// unbounded.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   valid/load/store  execute-stage op qualifiers (store wins if both set)
//   fun3, mem_mask    access size/sign and unshifted lane mask
//   addr, wdata       effective address and unshifted store data
//   stall             combinational pipeline hold
//   rd_valid/rd_data  completion pulse and extended load result
//   misaligned        combinational alignment-fault pulse (no bus op)
//   bus_error         timeout abort pulse, coincident with rd_valid
//   mem_*             data-memory request/response bus
module riscv_lsu #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            fun3,
  input  logic [3:0]            mem_mask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              fun3_q, fun3_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;
  logic                    bus_err_q, bus_err_d;

  logic                    op_c;
  logic                    misalign_c;
  logic                    accept_c;
  logic                    timeout_c;
  logic [DATA_W-1:0]       shifted_c;
  logic [DATA_W-1:0]       load_ext_c;

  // Request qualification and alignment check
  assign op_c = valid & (load | store);

  always_comb begin
    misalign_c = 1'b0;
    case (fun3)
      F3_B, F3_BU: misalign_c = 1'b0;
      F3_H, F3_HU: misalign_c = addr[0];
      default:     misalign_c = (addr[1:0] != 2'b00);
    endcase
  end

  assign accept_c = (state_q == ST_IDLE) & op_c & ~misalign_c;

  // Load data extraction from the latched byte offset and size
  assign shifted_c = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext_c = shifted_c;
    case (fun3_q)
      F3_B:    load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      F3_BU:   load_ext_c = {24'd0, shifted_c[7:0]};
      F3_H:    load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      F3_HU:   load_ext_c = {16'd0, shifted_c[15:0]};
      default: load_ext_c = shifted_c;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog: cleared on entering REQ, counts every REQ/WAIT cycle
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c) begin
      cnt_d = '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the edge at which the count reaches the limit
  assign timeout_c = (state_q == ST_REQ || state_q == ST_WAIT) &&
                     ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, CNT_W};
  assign timeout_c      = 1'b0;
`endif

  // Next-state and datapath latch logic
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    fun3_d    = fun3_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_data_d = rd_data_q;
    bus_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_REQ;
          off_d   = addr[1:0];
          fun3_d  = fun3;
          we_d    = store;
          addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = wdata << {addr[1:0], 3'b000};
          wstrb_d = store ? 4'(mem_mask << addr[1:0]) : 4'b0000;
        end
      end
      ST_REQ: begin
        // A handshake in the abort cycle completes normally; WAIT will time out
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end else if (timeout_c) begin
          state_d   = ST_DONE;
          bus_err_d = 1'b1;
          rd_data_d = '0;
        end
      end
      ST_WAIT: begin
        // A response in the abort cycle wins over the timeout
        if (mem_rsp_valid) begin
          state_d   = ST_DONE;
          rd_data_d = we_q ? '0 : load_ext_c;
        end else if (timeout_c) begin
          state_d   = ST_DONE;
          bus_err_d = 1'b1;
          rd_data_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      fun3_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      fun3_q    <= fun3_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_data_q <= rd_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs; stall and misaligned react to the same-cycle op, forced low in reset
  assign stall         = ~rst & (accept_c | (state_q == ST_REQ) | (state_q == ST_WAIT));
  assign misaligned    = ~rst & (state_q == ST_IDLE) & op_c & misalign_c;
  assign rd_valid      = (state_q == ST_DONE);
  assign rd_data       = rd_data_q;
  assign bus_error     = bus_err_q;
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: reset abandon, word load latency,
// load extension, store alignment with back-pressure, alignment faults,
// back-to-back ops, and (with LSU_TIMEOUT_EN) the timeout abort.
module tb_riscv_lsu;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, load, store;
  logic [2:0]  fun3;
  logic [3:0]  mem_mask;
  logic [31:0] addr, wdata;
  logic        stall, rd_valid, misaligned, bus_error;
  logic [31:0] rd_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;

  int total = 0;
  int bad   = 0;

  riscv_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .load(load), .store(store),
    .fun3(fun3), .mem_mask(mem_mask), .addr(addr), .wdata(wdata),
    .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data),
    .misaligned(misaligned), .bus_error(bus_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; load = 0; store = 0; fun3 = 3'b000; mem_mask = 4'b0000;
    addr = 32'h0; wdata = 32'h0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 32'h0;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
    valid = 1; load = ld; store = st; fun3 = f3; mem_mask = m; addr = a; wdata = wd;
  endtask

  // Drives one load with immediate ready/response; returns DONE-cycle outputs
  task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         output logic got_valid, output logic [31:0] got_data);
    step(); set_op(1, 0, f3, 4'b1111, a, 32'h0); mem_req_ready = 1;
    step();
    step(); mem_rsp_valid = 1; mem_rdata = rd; mem_req_ready = 0;
    step(); mem_rsp_valid = 0; valid = 0; load = 0; #1;
    got_valid = rd_valid; got_data = rd_data;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1;
    step(); step(); #1;
    total++; if ({stall, rd_valid, misaligned, bus_error, mem_req_valid, mem_we} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {stall, rd_valid, misaligned, bus_error, mem_req_valid, mem_we}); end
    total++; if ({rd_data, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rd_data, mem_addr, mem_wdata, mem_wstrb}); end
    rst = 0;
    // Start a load, reach WAIT, then reset with the response arriving late
    step(); set_op(1, 0, 3'b010, 4'b1111, 32'h100, 32'h0); mem_req_ready = 1;
    step();
    step(); #1;
    total++; if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_in_wait got stall=%b req=%b exp stall=1 req=0", stall, mem_req_valid); end
    rst = 1; valid = 0; load = 0; mem_req_ready = 0;
    step(); rst = 0; mem_rsp_valid = 1; mem_rdata = 32'hCAFEF00D; #1;
    total++; if ({stall, rd_valid, mem_req_valid, rd_data, mem_addr} !== 67'h0) begin bad++; $display("FAIL rst_after got=%h exp=0", {stall, rd_valid, mem_req_valid, rd_data, mem_addr}); end
    step(); mem_rsp_valid = 0; #1;
    total++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || stall !== 1'b0) begin bad++; $display("FAIL rst_late_rsp got rd_valid=%b rd_data=%h stall=%b exp 0 0 0", rd_valid, rd_data, stall); end
    step(); #1;
    total++; if (rd_valid !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_quiet got rd_valid=%b req=%b exp 0 0", rd_valid, mem_req_valid); end
  endtask

  task automatic test_load_word();
    idle_inputs();
    step(); set_op(1, 0, 3'b010, 4'b1111, 32'h100, 32'h0); mem_req_ready = 1; #1;
    total++; if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL lw_t0 got stall=%b req=%b exp 1 0", stall, mem_req_valid); end
    step(); #1;
    total++; if (stall !== 1'b1 || mem_req_valid !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL lw_t1 got stall=%b req=%b rdv=%b exp 1 1 0", stall, mem_req_valid, rd_valid); end
    total++; if (mem_addr !== 32'h100 || mem_wstrb !== 4'b0000 || mem_we !== 1'b0) begin bad++; $display("FAIL lw_fields got addr=%h wstrb=%b we=%b exp 100 0000 0", mem_addr, mem_wstrb, mem_we); end
    step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF; #1;
    total++; if (stall !== 1'b1 || mem_req_valid !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL lw_t2 got stall=%b req=%b rdv=%b exp 1 0 0", stall, mem_req_valid, rd_valid); end
    step(); mem_rsp_valid = 0; valid = 0; load = 0; #1;
    total++; if (rd_valid !== 1'b1 || stall !== 1'b0 || rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_t3 got rdv=%b stall=%b data=%h exp 1 0 deadbeef", rd_valid, stall, rd_data); end
    step(); #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL lw_pulse got rdv=%b exp 0", rd_valid); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b100, 3'b001, 3'b011};
    logic [31:0] ad [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h104};
    logic [31:0] rd [8] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                            32'h80FF0000, 32'h1234567F, 32'h12347FFE, 32'h89ABCDEF};
    logic [31:0] ex [8] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                            32'hFFFFFFFF, 32'h0000007F, 32'h00007FFE, 32'h89ABCDEF};
    logic        gv;
    logic [31:0] gd;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      load_op(f3[i], ad[i], rd[i], gv, gd);
      total++; if (gv !== 1'b1 || gd !== ex[i]) begin bad++; $display("FAIL ext_%0d got valid=%b data=%h exp 1 %h", i, gv, gd, ex[i]); end
    end
  endtask

  task automatic test_store_hold();
    idle_inputs();
    step(); set_op(0, 1, 3'b001, 4'b0011, 32'h202, 32'h1234ABCD); #1;
    total++; if (stall !== 1'b1 || misaligned !== 1'b0) begin bad++; $display("FAIL sh_t0 got stall=%b mis=%b exp 1 0", stall, misaligned); end
    for (int c = 0; c < 4; c++) begin
      step();
      mem_req_ready = (c == 3);
      mem_rsp_valid = (c == 1);  // response during REQ must be ignored
      #1;
      total++; if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
                   mem_wdata !== 32'hABCD0000 || mem_wstrb !== 4'b1100 || stall !== 1'b1) begin
        bad++; $display("FAIL sh_hold_%0d got req=%b we=%b addr=%h wd=%h strb=%b stall=%b exp 1 1 200 abcd0000 1100 1", c, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, stall);
      end
    end
    step(); mem_req_ready = 0; mem_rsp_valid = 1; #1;
    total++; if (mem_req_valid !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL sh_wait got req=%b stall=%b exp 0 1", mem_req_valid, stall); end
    step(); mem_rsp_valid = 0; valid = 0; store = 0; #1;
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0 || stall !== 1'b0) begin bad++; $display("FAIL sh_done got rdv=%b data=%h stall=%b exp 1 0 0", rd_valid, rd_data, stall); end
  endtask

  task automatic test_misaligned();
    logic        ld [2] = '{1'b1, 1'b0};
    logic [2:0]  f3 [2] = '{3'b010, 3'b001};
    logic [31:0] ad [2] = '{32'h101, 32'h203};
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      step(); set_op(ld[i], ~ld[i], f3[i], 4'b0011, ad[i], 32'h55); mem_req_ready = 1; #1;
      total++; if (misaligned !== 1'b1 || stall !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_%0d got mis=%b stall=%b req=%b exp 1 0 0", i, misaligned, stall, mem_req_valid); end
      step(); idle_inputs(); #1;
      total++; if (misaligned !== 1'b0 || mem_req_valid !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mis_after_%0d got mis=%b req=%b rdv=%b exp 0 0 0", i, misaligned, mem_req_valid, rd_valid); end
    end
    // Byte store at lane 3 never faults
    step(); set_op(0, 1, 3'b000, 4'b0001, 32'h203, 32'h000000AB); mem_req_ready = 1; #1;
    total++; if (misaligned !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL sb_accept got mis=%b stall=%b exp 0 1", misaligned, stall); end
    step(); #1;
    total++; if (mem_req_valid !== 1'b1 || mem_wstrb !== 4'b1000 || mem_wdata !== 32'hAB000000 || mem_addr !== 32'h200) begin bad++; $display("FAIL sb_fields got req=%b strb=%b wd=%h addr=%h exp 1 1000 ab000000 200", mem_req_valid, mem_wstrb, mem_wdata, mem_addr); end
    step(); mem_req_ready = 0; mem_rsp_valid = 1;
    step(); mem_rsp_valid = 0; valid = 0; store = 0; #1;
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin bad++; $display("FAIL sb_done got rdv=%b data=%h exp 1 0", rd_valid, rd_data); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    step(); set_op(1, 0, 3'b010, 4'b1111, 32'h108, 32'h0); mem_req_ready = 1;
    step();
    step(); mem_rsp_valid = 1; mem_rdata = 32'h11111111;
    step(); mem_rsp_valid = 0; #1;  // op inputs still asserted in DONE
    total++; if (rd_valid !== 1'b1 || stall !== 1'b0 || rd_data !== 32'h11111111 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_done1 got rdv=%b stall=%b data=%h req=%b exp 1 0 11111111 0", rd_valid, stall, rd_data, mem_req_valid); end
    step(); set_op(1, 0, 3'b010, 4'b1111, 32'h10C, 32'h0); #1;
    total++; if (stall !== 1'b1 || rd_valid !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got stall=%b rdv=%b req=%b exp 1 0 0", stall, rd_valid, mem_req_valid); end
    step(); #1;
    total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h10C) begin bad++; $display("FAIL b2b_req2 got req=%b addr=%h exp 1 10c", mem_req_valid, mem_addr); end
    step(); mem_rsp_valid = 1; mem_rdata = 32'h22222222;
    step(); mem_rsp_valid = 0; valid = 0; load = 0; #1;
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'h22222222) begin bad++; $display("FAIL b2b_done2 got rdv=%b data=%h exp 1 22222222", rd_valid, rd_data); end
    step(); #1;
    total++; if (rd_valid !== 1'b0 || mem_req_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL b2b_idle2 got rdv=%b req=%b stall=%b exp 0 0 0", rd_valid, mem_req_valid, stall); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    idle_inputs();
    step(); set_op(1, 0, 3'b010, 4'b1111, 32'h300, 32'h0); mem_req_ready = 1;
    step(); #1;  // first REQ cycle
    for (int c = 0; c < 3; c++) begin
      step(); mem_req_ready = 0; #1;
      total++; if (bus_error !== 1'b0 || stall !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL to_wait_%0d got err=%b stall=%b rdv=%b exp 0 1 0", c, bus_error, stall, rd_valid); end
    end
    step(); #1;
    total++; if (bus_error !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 32'h0 || stall !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL to_abort got err=%b rdv=%b data=%h stall=%b req=%b exp 1 1 0 0 0", bus_error, rd_valid, rd_data, stall, mem_req_valid); end
    step(); idle_inputs(); #1;
    total++; if (bus_error !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL to_pulse got err=%b rdv=%b exp 0 0", bus_error, rd_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_hold();
    test_misaligned();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
